// File: rtl/ieee754_division.sv
// IEEE-754 single-precision divider: Number1 / Number2, one restoring quotient bit per cycle.
// Latency: 26 cycles from accepted start to done on the normal path, 1 cycle for special operands.
// Backpressure: start is sampled only while idle (busy low); requests while busy are dropped.
// Ports: clk/rst_n clock and async active-low reset; start/Number1/Number2 request and operands;
//        busy/done status; Mantissa/Exponent/sign/div_by_zero registered result, held until next done.
module ieee754_division (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] Number1,
  input  logic [31:0] Number2,
  output logic        busy,
  output logic        done,
  output logic [22:0] Mantissa,
  output logic [7:0]  Exponent,
  output logic        sign,
  output logic        div_by_zero
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_DIVIDE    = 2'd1;
  localparam logic [1:0] S_NORMALIZE = 2'd2;
  localparam logic [1:0] S_SPECIAL   = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_n1;
  logic [31:0] r_n2;
  logic [24:0] r_rem;
  logic [24:0] r_q;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [22:0] r_mant;
  logic [7:0]  r_exp;
  logic        r_sign;
  logic        r_dbz;

  // Any zero (incl. flushed denormal), inf or NaN operand takes the special path.
  logic w_in_special;
  assign w_in_special = (Number1[30:23] == 8'h00) || (Number1[30:23] == 8'hFF) ||
                        (Number2[30:23] == 8'h00) || (Number2[30:23] == 8'hFF);

  // Classification of the latched operands for the SPECIAL result.
  logic w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
  assign w_a_zero = (r_n1[30:23] == 8'h00);
  assign w_a_inf  = (r_n1[30:23] == 8'hFF) && (r_n1[22:0] == 23'd0);
  assign w_a_nan  = (r_n1[30:23] == 8'hFF) && (r_n1[22:0] != 23'd0);
  assign w_b_zero = (r_n2[30:23] == 8'h00);
  assign w_b_inf  = (r_n2[30:23] == 8'hFF) && (r_n2[22:0] == 23'd0);
  assign w_b_nan  = (r_n2[30:23] == 8'hFF) && (r_n2[22:0] != 23'd0);

  logic [7:0]  w_sp_exp;
  logic [22:0] w_sp_mant;
  logic        w_sp_dbz;

  always_comb begin
    w_sp_exp  = 8'hFF;
    w_sp_mant = 23'h400000;
    w_sp_dbz  = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_sp_mant = 23'h400000;
    end else if (w_b_zero || w_a_inf) begin
      // Divide-by-zero flag only when the dividend is finite.
      w_sp_mant = 23'd0;
      w_sp_dbz  = w_b_zero && !w_a_inf;
    end else begin
      w_sp_exp  = 8'h00;
      w_sp_mant = 23'd0;
    end
  end

  // Restoring step: remainder stays below 2*B, so 25 bits suffice after the shift.
  logic [23:0] w_b;
  logic        w_ge;
  logic [24:0] w_diff;
  logic [24:0] w_rem_nxt;
  assign w_b       = {1'b1, r_n2[22:0]};
  assign w_ge      = (r_rem >= {1'b0, w_b});
  assign w_diff    = w_ge ? (r_rem - {1'b0, w_b}) : r_rem;
  assign w_rem_nxt = w_diff << 1;

  // Quotient lies in (0.5, 2): q[24] tells whether a one-bit left shift is needed.
  logic signed [9:0] w_e;
  logic signed [9:0] w_e_fin;
  assign w_e     = $signed({2'b00, r_n1[30:23]}) - $signed({2'b00, r_n2[30:23]}) + 10'sd127;
  assign w_e_fin = r_q[24] ? w_e : (w_e - 10'sd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_n1    <= 32'd0;
      r_n2    <= 32'd0;
      r_rem   <= 25'd0;
      r_q     <= 25'd0;
      r_cnt   <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mant  <= 23'd0;
      r_exp   <= 8'd0;
      r_sign  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n1    <= Number1;
            r_n2    <= Number2;
            r_rem   <= {2'b01, Number1[22:0]};
            r_q     <= 25'd0;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b1;
            r_state <= w_in_special ? S_SPECIAL : S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          r_q   <= {r_q[23:0], w_ge};
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd24) begin
            r_state <= S_NORMALIZE;
          end
        end
        S_NORMALIZE: begin
          r_sign <= r_n1[31] ^ r_n2[31];
          r_dbz  <= 1'b0;
          if (w_e_fin >= 10'sd255) begin
            r_exp  <= 8'hFF;
            r_mant <= 23'd0;
          end else if (w_e_fin <= 10'sd0) begin
            r_exp  <= 8'h00;
            r_mant <= 23'd0;
          end else begin
            r_exp  <= w_e_fin[7:0];
            r_mant <= r_q[24] ? r_q[23:1] : r_q[22:0];
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        S_SPECIAL: begin
          r_sign  <= r_n1[31] ^ r_n2[31];
          r_exp   <= w_sp_exp;
          r_mant  <= w_sp_mant;
          r_dbz   <= w_sp_dbz;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign Mantissa    = r_mant;
  assign Exponent    = r_exp;
  assign sign        = r_sign;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_ieee754_division.sv
// Testbench for ieee754_division: scoreboard of expected results, per-scenario tasks.
module tb_ieee754_division;

  typedef struct packed {
    logic        dbz;
    logic        sgn;
    logic [7:0]  ex;
    logic [22:0] man;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] Number1;
  logic [31:0] Number2;
  logic        busy;
  logic        done;
  logic [22:0] Mantissa;
  logic [7:0]  Exponent;
  logic        sign;
  logic        div_by_zero;

  int vectors = 0;
  int miscompares = 0;
  res_t sb[$];
  res_t obs;
  assign obs = {div_by_zero, sign, Exponent, Mantissa};

  always #5 clk = ~clk;

  ieee754_division dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .Number1(Number1), .Number2(Number2),
    .busy(busy), .done(done),
    .Mantissa(Mantissa), .Exponent(Exponent), .sign(sign), .div_by_zero(div_by_zero)
  );

  // Reference for normal (finite, nonzero, non-denormal) operands.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic [63:0] q;
    int e;
    r.dbz = 1'b0;
    r.sgn = a[31] ^ b[31];
    q = ({40'd0, 1'b1, a[22:0]} << 24) / {40'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q[24]) r.man = q[23:1];
    else begin
      r.man = q[22:0];
      e = e - 1;
    end
    if (e >= 255) begin
      r.ex = 8'hFF; r.man = 23'd0;
    end else if (e <= 0) begin
      r.ex = 8'h00; r.man = 23'd0;
    end else begin
      r.ex = e[7:0];
    end
    return r;
  endfunction

  // Drives a start pulse at the current negedge; returns at the negedge after acceptance.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input res_t exp_r);
    Number1 = a;
    Number2 = b;
    start = 1'b1;
    sb.push_back(exp_r);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (done !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; Number1 = 32'd0; Number2 = 32'd0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status: busy=%b done=%b, want 0 0", busy, done);
    end
    vectors++;
    if (obs !== 33'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, want 0", obs);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_normal;
    int k;
    int bad;
    res_t e;
    bad = 0; k = 0;
    launch(32'h40C00000, 32'h40000000, '{1'b0, 1'b0, 8'h80, 23'h400000});
    while (done !== 1'b1 && k < 60) begin
      if (busy !== 1'b1) bad++;
      @(negedge clk);
      k++;
    end
    vectors++;
    if (k != 26) begin
      miscompares++;
      $display("FAIL normal_latency: got %0d, want 26", k);
    end
    vectors++;
    if (bad != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL normal_busy: low cycles in window=%0d busy at done=%b, want 0 0", bad, busy);
    end
    e = sb.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL normal_6div2: got %h, want %h", obs, e);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || obs !== e) begin
      miscompares++;
      $display("FAIL normal_hold: done=%b res=%h, want 0 %h", done, obs, e);
    end
  endtask

  task automatic test_shift;
    int k;
    res_t e;
    launch(32'h3F800000, 32'h40400000, '{1'b0, 1'b0, 8'h7D, 23'h2AAAAA});
    wait_done(k);
    vectors++;
    if (k != 26) begin
      miscompares++;
      $display("FAIL shift_latency: got %0d, want 26", k);
    end
    e = sb.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL shift_1div3: got %h, want %h", obs, e);
    end
  endtask

  task automatic test_sign_restart;
    int k;
    int extra;
    res_t e;
    k = 0; extra = 0;
    launch(32'hC0F00000, 32'h40200000, '{1'b0, 1'b1, 8'h80, 23'h400000});
    while (done !== 1'b1 && k < 60) begin
      if (k == 10) begin
        start = 1'b1; Number1 = 32'h3F800000; Number2 = 32'h40400000;
      end
      if (k == 11) start = 1'b0;
      @(negedge clk);
      k++;
    end
    vectors++;
    if (k != 26) begin
      miscompares++;
      $display("FAIL restart_latency: got %0d, want 26", k);
    end
    e = sb.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL restart_result: got %h, want %h", obs, e);
    end
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    vectors++;
    if (extra != 0 || obs !== e) begin
      miscompares++;
      $display("FAIL restart_no_extra: extra dones=%0d res=%h, want 0 %h", extra, obs, e);
    end
  endtask

  task automatic test_specials;
    logic [31:0] ta [7];
    logic [31:0] tb [7];
    res_t te [7];
    int k;
    res_t e;
    ta[0] = 32'h3F800000; tb[0] = 32'h00000000; te[0] = '{1'b1, 1'b0, 8'hFF, 23'h000000};
    ta[1] = 32'h00000000; tb[1] = 32'h00000000; te[1] = '{1'b0, 1'b0, 8'hFF, 23'h400000};
    ta[2] = 32'h7F800000; tb[2] = 32'h3F800000; te[2] = '{1'b0, 1'b0, 8'hFF, 23'h000000};
    ta[3] = 32'h7FC00000; tb[3] = 32'h3F800000; te[3] = '{1'b0, 1'b0, 8'hFF, 23'h400000};
    ta[4] = 32'hFF800000; tb[4] = 32'h7F800000; te[4] = '{1'b0, 1'b1, 8'hFF, 23'h400000};
    ta[5] = 32'h80000000; tb[5] = 32'h40000000; te[5] = '{1'b0, 1'b1, 8'h00, 23'h000000};
    ta[6] = 32'h00400000; tb[6] = 32'h7F800000; te[6] = '{1'b0, 1'b0, 8'h00, 23'h000000};
    for (int i = 0; i < 7; i++) begin
      launch(ta[i], tb[i], te[i]);
      wait_done(k);
      vectors++;
      if (k != 1) begin
        miscompares++;
        $display("FAIL special%0d_latency: got %0d, want 1", i, k);
      end
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL special%0d_result: got %h, want %h", i, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_range;
    int k;
    res_t e;
    launch(32'h7F000000, 32'h00800000, '{1'b0, 1'b0, 8'hFF, 23'h000000});
    wait_done(k);
    e = sb.pop_front();
    vectors++;
    if (k != 26 || obs !== e) begin
      miscompares++;
      $display("FAIL range_overflow: lat=%0d res=%h, want 26 %h", k, obs, e);
    end
    @(negedge clk);
    launch(32'h00800000, 32'h7F000000, '{1'b0, 1'b0, 8'h00, 23'h000000});
    wait_done(k);
    e = sb.pop_front();
    vectors++;
    if (k != 26 || obs !== e) begin
      miscompares++;
      $display("FAIL range_underflow: lat=%0d res=%h, want 26 %h", k, obs, e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int k;
    int dones;
    res_t e;
    dones = 0;
    launch(32'h40C00000, 32'h40000000, '{1'b0, 1'b0, 8'h80, 23'h400000});
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || obs !== 33'd0) begin
      miscompares++;
      $display("FAIL midreset_clear: busy=%b done=%b res=%h, want 0 0 0", busy, done, obs);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL midreset_no_done: got %0d dones, want 0", dones);
    end
    launch(32'h40C00000, 32'h40000000, '{1'b0, 1'b0, 8'h80, 23'h400000});
    wait_done(k);
    e = sb.pop_front();
    vectors++;
    if (k != 26 || obs !== e) begin
      miscompares++;
      $display("FAIL midreset_rerun: lat=%0d res=%h, want 26 %h", k, obs, e);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] a [6];
    logic [31:0] b [6];
    int k;
    res_t e;
    for (int i = 0; i < 6; i++) begin
      a[i] = {1'($urandom_range(1, 0)), 8'($urandom_range(154, 100)), 23'($urandom)};
      b[i] = {1'($urandom_range(1, 0)), 8'($urandom_range(154, 100)), 23'($urandom)};
    end
    launch(a[0], b[0], model(a[0], b[0]));
    for (int i = 0; i < 6; i++) begin
      wait_done(k);
      e = sb.pop_front();
      vectors++;
      if (k != 26 || obs !== e) begin
        miscompares++;
        $display("FAIL b2b%0d: a=%h b=%h lat=%0d res=%h, want 26 %h", i, a[i], b[i], k, obs, e);
      end
      // Next request issued while done is still high.
      if (i < 5) launch(a[i+1], b[i+1], model(a[i+1], b[i+1]));
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_shift();
    test_sign_restart();
    test_specials();
    test_range();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
